c_input_conditioner: RTL and testbench

- Upstream front-end for the sequence-detector FSM stage.
- Takes a raw, asynchronous, possibly bouncing input `din` and produces a clean, clock-synchronous level `c_level` plus one-cycle edge pulses.
- `c_level` drives the downstream FSM's `C` input, so the FSM only ever sees debounced, metastability-safe transitions.

---
 rtl/c_input_conditioner_pkg.sv | 18 +
 rtl/c_input_conditioner_if.sv | 30 +++
 rtl/c_input_conditioner_bit_sync.sv | 27 ++
 rtl/c_input_conditioner.sv | 129 ++++++++++++
 tb/tb_c_input_conditioner.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/c_input_conditioner_pkg.sv
// Shared types and default parameters for the C-input conditioner.
// Provides:
//   cond_state_t     - debounce FSM state (IDLE_LO, CHK_HI, IDLE_HI, CHK_LO).
//   SYNC_STAGES_DEF  - default synchronizer depth.
//   DB_CYCLES_DEF    - default number of equal samples needed to commit a level.
package c_cond_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        CHK_HI  = 2'b01,
        IDLE_HI = 2'b11,
        CHK_LO  = 2'b10
    } cond_state_t;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned DB_CYCLES_DEF   = 4;

endpackage

// File: rtl/c_input_conditioner_if.sv
// Signal bundle between the raw-input source and the conditioner.
//   din        raw asynchronous input (source -> conditioner)
//   c_level    debounced level, feeds the downstream FSM C input
//   c_rise     one-cycle pulse on a committed 0->1 transition
//   c_fall     one-cycle pulse on a committed 1->0 transition
//   busy       high while a candidate transition is being qualified
//   glitch_cnt saturating abort counter (only with C_INPUT_CONDITIONER_GLITCH_CNT_EN)
// Modports: master = source/consumer side, slave = conditioner.
interface c_input_conditioner_if;

    logic       din;
    logic       c_level;
    logic       c_rise;
    logic       c_fall;
    logic       busy;
`ifdef C_INPUT_CONDITIONER_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (output din, input c_level, input c_rise, input c_fall,
                    input busy, input glitch_cnt);
    modport slave  (input din, output c_level, output c_rise, output c_fall,
                    output busy, output glitch_cnt);
`else
    modport master (output din, input c_level, input c_rise, input c_fall,
                    input busy);
    modport slave  (input din, output c_level, output c_rise, output c_fall,
                    output busy);
`endif

endinterface

// File: rtl/c_input_conditioner_bit_sync.sv
// N-flop single-bit synchronizer with asynchronous active-low reset to 0.
//   clk   clock, rising edge
//   rst_n asynchronous active-low reset
//   d     asynchronous input
//   q     synchronized output (last stage of the chain)
module bit_sync #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/c_input_conditioner.sv
// Input conditioner: synchronizes and debounces a raw input into a clean
// level c_level with one-cycle c_rise/c_fall pulses and a busy flag.
// Ports:
//   clk   clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   c_input_conditioner_if.slave (din in; c_level, c_rise, c_fall,
//         busy and optional glitch_cnt out)
// Optional feature: define C_INPUT_CONDITIONER_GLITCH_CNT_EN to add the
// saturating 8-bit glitch_cnt output counting aborted qualifications.
module c_input_conditioner
    import c_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    c_input_conditioner_if.slave      bus
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s;
    cond_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;
`ifdef C_INPUT_CONDITIONER_GLITCH_CNT_EN
    logic [7:0]       glitch_q;
`endif

    bit_sync #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.din),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE_LO;
            cnt      <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef C_INPUT_CONDITIONER_GLITCH_CNT_EN
            glitch_q <= '0;
`endif
        end else begin
            // Pulses only survive the cycle in which a commit happens.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (s) begin
                        state  <= CHK_HI;
                        cnt    <= CNT_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                CHK_HI: begin
                    if (s) begin
                        if (cnt == CNT_LAST) begin
                            state   <= IDLE_HI;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        state  <= IDLE_LO;
                        cnt    <= '0;
                        busy_q <= 1'b0;
`ifdef C_INPUT_CONDITIONER_GLITCH_CNT_EN
                        if (glitch_q != 8'hFF) glitch_q <= glitch_q + 8'd1;
`endif
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state  <= CHK_LO;
                        cnt    <= CNT_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                CHK_LO: begin
                    if (!s) begin
                        if (cnt == CNT_LAST) begin
                            state   <= IDLE_LO;
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        state  <= IDLE_HI;
                        cnt    <= '0;
                        busy_q <= 1'b0;
`ifdef C_INPUT_CONDITIONER_GLITCH_CNT_EN
                        if (glitch_q != 8'hFF) glitch_q <= glitch_q + 8'd1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE_LO;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.c_level    = level_q;
    assign bus.c_rise     = rise_q;
    assign bus.c_fall     = fall_q;
    assign bus.busy       = busy_q;
`ifdef C_INPUT_CONDITIONER_GLITCH_CNT_EN
    assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_c_input_conditioner.sv
// Self-checking bench for c_input_conditioner: directed scenarios followed
// by randomized din bursts, all compared against a run-length debounce model.
module tb_c_input_conditioner;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DB_CYCLES   = 4;

    logic clk;
    logic rst_n;

    c_input_conditioner_if cif ();

    c_input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: din delayed by SYNC_STAGES edges, then a level flips
    // once DB_CYCLES consecutive delayed samples disagree with it.
    bit q_delay[$];
    int run;
    bit m_level, m_rise, m_fall, m_busy;
    int m_gcnt;

    int rise_pulses;
    int fall_pulses;

    function automatic void model_reset();
        q_delay.delete();
        for (int unsigned i = 0; i < SYNC_STAGES; i++) q_delay.push_back(1'b0);
        run     = 0;
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_busy  = 1'b0;
        m_gcnt  = 0;
    endfunction

    function automatic void model_step(bit d);
        bit s;
        s = q_delay.pop_front();
        q_delay.push_back(d);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_level) begin
            run++;
            if (run == int'(DB_CYCLES)) begin
                m_level = s;
                m_rise  = s;
                m_fall  = !s;
                run     = 0;
            end
        end else begin
            if (run > 0 && m_gcnt < 255) m_gcnt++;
            run = 0;
        end
        m_busy = (run != 0);
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".c_level"}, {7'd0, cif.c_level}, {7'd0, m_level});
        chk({tag, ".c_rise"},  {7'd0, cif.c_rise},  {7'd0, m_rise});
        chk({tag, ".c_fall"},  {7'd0, cif.c_fall},  {7'd0, m_fall});
        chk({tag, ".busy"},    {7'd0, cif.busy},    {7'd0, m_busy});
        chk({tag, ".pulse_excl"}, {7'd0, cif.c_rise & cif.c_fall}, 8'd0);
`ifdef C_INPUT_CONDITIONER_GLITCH_CNT_EN
        chk({tag, ".glitch_cnt"}, cif.glitch_cnt, m_gcnt[7:0]);
`endif
    endtask

    // One clock: drive inputs on the falling edge, update the model on the
    // rising edge, sample DUT outputs 1 time unit later.
    task automatic tick(string tag, bit d, bit r);
        @(negedge clk);
        cif.din = d;
        rst_n   = r;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(d);
        #1;
        if (cif.c_rise === 1'b1) rise_pulses++;
        if (cif.c_fall === 1'b1) fall_pulses++;
        check_all(tag);
    endtask

    initial begin
        int hold;
        bit v;
        vectors     = 0;
        miscompares = 0;
        rise_pulses = 0;
        fall_pulses = 0;
        rst_n   = 1'b0;
        cif.din = 1'b0;
        model_reset();

        // Reset held with din toggling: everything stays 0.
        for (int i = 0; i < 8; i++) tick("reset", 1'($urandom), 1'b0);
        tick("release", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick("idle", 1'b0, 1'b1);

        // Glitch reject: three high samples are one short of a commit.
        for (int i = 0; i < 3; i++) tick("glitch_hi", 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick("glitch_lo", 1'b0, 1'b1);
        chk("glitch_level", {7'd0, cif.c_level}, 8'd0);
        chk("glitch_no_rise", rise_pulses[7:0], 8'd0);
`ifdef C_INPUT_CONDITIONER_GLITCH_CNT_EN
        chk("glitch_cnt_one", cif.glitch_cnt, 8'd1);
`endif

        // Clean rise: c_rise appears after E5 and drops after E6.
        for (int i = 0; i < 6; i++) tick("rise", 1'b1, 1'b1);
        chk("rise_level_E5", {7'd0, cif.c_level}, 8'd1);
        chk("rise_pulse_E5", {7'd0, cif.c_rise}, 8'd1);
        tick("rise_E6", 1'b1, 1'b1);
        chk("rise_pulse_E6", {7'd0, cif.c_rise}, 8'd0);
        for (int i = 0; i < 3; i++) tick("hold_hi", 1'b1, 1'b1);

        // Clean fall: exactly one c_fall pulse after the 6th edge.
        fall_pulses = 0;
        for (int i = 0; i < 6; i++) tick("fall", 1'b0, 1'b1);
        chk("fall_level_E5", {7'd0, cif.c_level}, 8'd0);
        chk("fall_pulse_E5", {7'd0, cif.c_fall}, 8'd1);
        for (int i = 0; i < 6; i++) tick("hold_lo", 1'b0, 1'b1);
        chk("fall_single", fall_pulses[7:0], 8'd1);

        // Bounce 1,1,0,1,1,1,1: single rise after requalification.
        rise_pulses = 0;
        tick("bounce", 1'b1, 1'b1);
        tick("bounce", 1'b1, 1'b1);
        tick("bounce", 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick("bounce_hold", 1'b1, 1'b1);
        chk("bounce_single_rise", rise_pulses[7:0], 8'd1);
        chk("bounce_level", {7'd0, cif.c_level}, 8'd1);
        for (int i = 0; i < 8; i++) tick("back_lo", 1'b0, 1'b1);

        // Reset mid-CHK_HI at cnt=2: immediate idle, then fresh qualification.
        for (int i = 0; i < 4; i++) tick("pre_rst", 1'b1, 1'b1);
        chk("pre_rst_busy", {7'd0, cif.busy}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        tick("in_rst", 1'b1, 1'b0);
        rise_pulses = 0;
        for (int i = 0; i < 5; i++) tick("post_rst", 1'b1, 1'b1);
        chk("post_rst_no_rise_yet", rise_pulses[7:0], 8'd0);
        tick("post_rst_E5", 1'b1, 1'b1);
        chk("post_rst_rise", {7'd0, cif.c_rise}, 8'd1);

        // Randomized bursts of varying length.
        for (int b = 0; b < 400; b++) begin
            v    = 1'($urandom);
            hold = $urandom_range(1, 8);
            for (int i = 0; i < hold; i++) tick("rand", v, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
